ifq_icache_resp: RTL and testbench

- Responder side of the fetch-queue cache interface.
- Accepts single-cycle cache_en requests carrying a fetch PC and returns a full 4-instruction line on dout/dout_valid, which the fetch queue pushes into its FIFO.
- Direct-mapped instruction cache with a refill FSM toward a simple beat-based memory port.
- Honours branch flush by suppressing the pending response.

---
 rtl/ifq_pkg.sv | 24 ++
 rtl/ifq_icache_array.sv | 61 ++++++
 rtl/ifq_icache_resp.sv | 169 ++++++++++++++++
 tb/tb_ifq_icache_resp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifq_pkg
// Brief    : Shared types and constants for the fetch-queue icache responder.
// Revision : 1.0 - initial release
// ============================================================================
package ifq_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_OFF_W     = 4;
    localparam int IFQ_DATA_W     = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MISS_REQ = 3'd2,
        REFILL   = 3'd3,
        RESPOND  = 3'd4
    } ifq_state_t;

    typedef logic [WORDS_PER_LINE-1:0][IFQ_DATA_W-1:0] ifq_line_t;

endpackage
`default_nettype wire

// File: rtl/ifq_icache_array.sv
`default_nettype none
// ============================================================================
// Module   : ifq_icache_array
// Brief    : Direct-mapped line, tag and valid storage; only valid bits reset.
// Revision : 1.0 - initial release
// ============================================================================
module ifq_icache_array
    import ifq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 24,
    parameter int IDX_W  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [IDX_W-1:0]                 i_rd_idx,
    output logic [WORDS_PER_LINE*DATA_W-1:0] o_rd_line,
    output logic [TAG_W-1:0]                 o_rd_tag,
    output logic                             o_rd_valid,
    input  logic [IDX_W-1:0]                 i_wr_idx,
    input  logic [WORDS_PER_LINE-1:0]        i_wr_word_en,
    input  logic [DATA_W-1:0]                i_wr_data,
    input  logic                             i_tag_we,
    input  logic [TAG_W-1:0]                 i_tag,
    input  logic                             i_tag_valid,
    input  logic                             i_inv_all
);
    localparam int NUM_LINES = 1 << IDX_W;

    logic [WORDS_PER_LINE*DATA_W-1:0] r_data [NUM_LINES];
    logic [TAG_W-1:0]                 r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0]             r_valid;

    always_ff @(posedge clk) begin
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (i_wr_word_en[w]) begin
                r_data[i_wr_idx][w*DATA_W +: DATA_W] <= i_wr_data;
            end
        end
        if (i_tag_we) begin
            r_tag[i_wr_idx] <= i_tag;
        end
    end

    // Invalidate-all wins over a coincident tag install.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (i_inv_all) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_wr_idx] <= i_tag_valid;
        end
    end

    assign o_rd_line  = r_data[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/ifq_icache_resp.sv
`default_nettype none
// ============================================================================
// Module   : ifq_icache_resp
// Brief    : Fetch-queue icache responder: 1-cycle hit, beat-based refill FSM.
// Revision : 1.0 - initial release
// ============================================================================
module ifq_icache_resp
    import ifq_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NUM_LINES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cache_en,
    input  logic [ADDR_W-1:0]                pc,
    input  logic                             flush,
    input  logic                             inv_all,
    output logic                             ready,
    output logic                             dout_valid,
    output logic [WORDS_PER_LINE*DATA_W-1:0] dout,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_rvalid,
    input  logic [DATA_W-1:0]                mem_rdata
);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int LINE_W = ADDR_W - LINE_OFF_W;
    localparam int TAG_W  = LINE_W - IDX_W;

    ifq_state_t r_state;
    ifq_state_t w_next;

    logic [LINE_W-1:0]                r_line;
    logic [1:0]                       r_beat;
    logic                             r_drop_resp;
    logic                             r_drop_inst;

    logic [IDX_W-1:0]                 w_idx;
    logic [TAG_W-1:0]                 w_tag;
    logic [WORDS_PER_LINE*DATA_W-1:0] w_rd_line;
    logic [TAG_W-1:0]                 w_rd_tag;
    logic                             w_rd_valid;
    logic                             w_hit;
    logic                             w_beat;
    logic                             w_last_beat;
    logic [WORDS_PER_LINE-1:0]        w_word_en;
    logic                             w_unused_pc_off;

    assign w_unused_pc_off = ^pc[LINE_OFF_W-1:0];
    assign w_idx           = r_line[IDX_W-1:0];
    assign w_tag           = r_line[LINE_W-1:IDX_W];

    assign w_hit       = w_rd_valid && (w_rd_tag == w_tag) && !inv_all;
    assign w_beat      = (r_state == REFILL) && mem_rvalid;
    assign w_last_beat = w_beat && (r_beat == 2'd3);

    always_comb begin
        w_word_en = '0;
        if (w_beat) begin
            w_word_en[r_beat] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        ready      = 1'b0;
        mem_req    = 1'b0;
        dout_valid = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (cache_en) begin
                    w_next = LOOKUP;
                end
            end
            LOOKUP: begin
                dout_valid = w_hit && !flush;
                w_next     = w_hit ? IDLE : MISS_REQ;
            end
            MISS_REQ: begin
                mem_req = 1'b1;
                w_next  = REFILL;
            end
            REFILL: begin
                if (w_last_beat) begin
                    w_next = RESPOND;
                end
            end
            RESPOND: begin
                dout_valid = !r_drop_resp && !flush;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // A flush in LOOKUP still lets a miss refill, so it must silence RESPOND.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line      <= '0;
            r_beat      <= 2'd0;
            r_drop_resp <= 1'b0;
            r_drop_inst <= 1'b0;
        end else begin
            if ((r_state == IDLE) && cache_en) begin
                r_line <= pc[ADDR_W-1:LINE_OFF_W];
            end
            if (r_state == MISS_REQ) begin
                r_beat <= 2'd0;
            end else if (w_beat) begin
                r_beat <= r_beat + 2'd1;
            end
            case (r_state)
                LOOKUP: begin
                    r_drop_resp <= flush;
                    r_drop_inst <= 1'b0;
                end
                MISS_REQ, REFILL: begin
                    if (flush) begin
                        r_drop_resp <= 1'b1;
                    end
                    if (inv_all) begin
                        r_drop_inst <= 1'b1;
                    end
                end
                RESPOND: begin
                    r_drop_resp <= 1'b0;
                    r_drop_inst <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dout     = dout_valid ? w_rd_line : '0;
    assign mem_addr = {r_line, {LINE_OFF_W{1'b0}}};

    ifq_icache_array #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk          (clk),
        .reset        (reset),
        .i_rd_idx     (w_idx),
        .o_rd_line    (w_rd_line),
        .o_rd_tag     (w_rd_tag),
        .o_rd_valid   (w_rd_valid),
        .i_wr_idx     (w_idx),
        .i_wr_word_en (w_word_en),
        .i_wr_data    (mem_rdata),
        .i_tag_we     (w_last_beat),
        .i_tag        (w_tag),
        .i_tag_valid  (!r_drop_inst && !inv_all),
        .i_inv_all    (inv_all)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifq_icache_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifq_icache_resp
// Brief    : Randomized transaction-level bench with a line-cache reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifq_icache_resp;

    localparam int NL = 16;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic         cache_en   = 1'b0;
    logic [31:0]  pc         = '0;
    logic         flush      = 1'b0;
    logic         inv_all    = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata  = '0;
    logic         ready;
    logic         dout_valid;
    logic [127:0] dout;
    logic         mem_req;
    logic [31:0]  mem_addr;

    ifq_icache_resp #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NUM_LINES (NL)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .cache_en   (cache_en),
        .pc         (pc),
        .flush      (flush),
        .inv_all    (inv_all),
        .ready      (ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic         s_ready, s_dv, s_req, s_prev_dv;
    logic [127:0] s_dout;
    logic [31:0]  s_addr;

    // Reference model: what each line of a direct-mapped cache should hold.
    bit           m_valid [NL];
    logic [23:0]  m_tag   [NL];
    logic [127:0] m_line  [NL];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    // Drive one cycle of inputs, sample outputs mid-cycle, advance past the edge.
    task automatic cyc(input logic en, input logic [31:0] a, input logic fl, input logic inv,
                       input logic rv, input logic [31:0] rd);
        cache_en = en; pc = a; flush = fl; inv_all = inv; mem_rvalid = rv; mem_rdata = rd;
        #2;
        s_prev_dv = s_dv;
        s_ready = ready; s_dv = dout_valid; s_dout = dout; s_req = mem_req; s_addr = mem_addr;
        if (s_dv && s_prev_dv) check("dv_back_to_back", 128'(1'b1), 128'(1'b0));
        @(posedge clk); #1;
    endtask

    task automatic idle_gap(input bit do_inv);
        cyc(1'b0, $urandom, 1'b0, do_inv, 1'($urandom_range(0, 1)), $urandom);
        check("gap_ready", 128'(s_ready), 128'(1'b1));
        check("gap_dv", 128'(s_dv), 128'(1'b0));
        if (do_inv) model_clear();
    endtask

    // fl_at/inv_at: -1 none, 0..3 on that beat, 4 in RESPOND, 5 in MISS_REQ.
    // rst_at: -1 none, else reset is pulsed just before that beat.
    task automatic run_txn(input logic [31:0] a, input bit fl_en, input bit fl_lk, input bit inv_lk,
                           input int fl_at, input int inv_at, input int lat, input int max_gap,
                           input logic [31:0] base, input int rst_at);
        int           idx;
        logic [23:0]  tg;
        logic [31:0]  la, w;
        bit           hit, drop, noinst, exp_dv;
        logic [127:0] beats;
        idx    = int'(a[7:4]);
        tg     = a[31:8];
        la     = {a[31:4], 4'h0};
        hit    = m_valid[idx] && (m_tag[idx] == tg) && !inv_lk;
        beats  = '0;

        cyc(1'b1, a, fl_en, 1'b0, 1'b0, 32'h0);
        check("req_ready", 128'(s_ready), 128'(1'b1));

        cyc(1'($urandom_range(0, 1)), $urandom, fl_lk, inv_lk, 1'($urandom_range(0, 1)), $urandom);
        check("lookup_ready", 128'(s_ready), 128'(1'b0));
        check("lookup_memreq", 128'(s_req), 128'(1'b0));
        check("hit_dv", 128'(s_dv), 128'(hit && !fl_lk));
        if (hit && !fl_lk) check("hit_dout", s_dout, m_line[idx]);
        if (inv_lk) model_clear();
        if (hit) return;

        drop   = fl_lk;
        noinst = 1'b0;
        cyc(1'($urandom_range(0, 1)), $urandom, fl_at == 5, inv_at == 5, 1'b0, 32'h0);
        check("miss_memreq", 128'(s_req), 128'(1'b1));
        check("miss_addr", 128'(s_addr), 128'(la));
        check("miss_dv", 128'(s_dv), 128'(1'b0));
        if (fl_at == 5) drop = 1'b1;
        if (inv_at == 5) begin model_clear(); noinst = 1'b1; end

        for (int i = 1; i < lat; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
            check("wait_memreq", 128'(s_req), 128'(1'b0));
            check("wait_ready", 128'(s_ready), 128'(1'b0));
        end

        for (int b = 0; b < 4; b++) begin
            if (b == rst_at) begin
                reset = 1'b0;
                cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
                check("rst_ready", 128'(s_ready), 128'(1'b1));
                check("rst_dv", 128'(s_dv), 128'(1'b0));
                reset = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, $urandom);
                    check("stray_ready", 128'(s_ready), 128'(1'b1));
                    check("stray_dv", 128'(s_dv), 128'(1'b0));
                    check("stray_memreq", 128'(s_req), 128'(1'b0));
                end
                model_clear();
                return;
            end
            for (int g = $urandom_range(0, max_gap); g > 0; g--) begin
                cyc(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b0, $urandom);
                check("gap_addr", 128'(s_addr), 128'(la));
            end
            w = (base != 0) ? base + 32'(b) : $urandom;
            beats[b*32 +: 32] = w;
            cyc(1'b0, 32'h0, fl_at == b, inv_at == b, 1'b1, w);
            check("beat_dv", 128'(s_dv), 128'(1'b0));
            check("beat_addr", 128'(s_addr), 128'(la));
            if (fl_at == b) drop = 1'b1;
            if (inv_at == b) begin model_clear(); noinst = 1'b1; end
        end

        cyc(1'b0, 32'h0, fl_at == 4, 1'b0, 1'b0, 32'h0);
        exp_dv = !drop && (fl_at != 4);
        check("resp_dv", 128'(s_dv), 128'(exp_dv));
        if (exp_dv) check("resp_dout", s_dout, beats);
        m_tag[idx]   = tg;
        m_line[idx]  = beats;
        m_valid[idx] = !noinst;
    endtask

    initial begin
        #1 reset = 1'b0;
        model_clear();
        s_dv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready0", 128'(ready), 128'(1'b1));
        check("rst_dv0", 128'(dout_valid), 128'(1'b0));
        check("rst_dout0", dout, 128'(0));
        check("rst_memreq0", 128'(mem_req), 128'(1'b0));
        check("rst_memaddr0", 128'(mem_addr), 128'(0));
        reset = 1'b1;

        run_txn(32'h100, 0, 0, 0, -1, -1, 5, 0, 32'hA0, -1);
        check("cold_line", m_line[0], {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        run_txn(32'h10C, 0, 0, 0, -1, -1, 3, 1, 32'h0, -1);
        run_txn(32'h200, 0, 0, 0, -1, -1, 2, 1, 32'h0, -1);
        run_txn(32'h100, 0, 0, 0, -1, -1, 2, 1, 32'h0, -1);
        run_txn(32'h330, 0, 0, 0, 2, -1, 2, 1, 32'h0, -1);
        run_txn(32'h334, 0, 0, 0, -1, -1, 2, 1, 32'h0, -1);
        run_txn(32'h440, 0, 0, 0, -1, 1, 2, 1, 32'h0, -1);
        run_txn(32'h440, 0, 0, 0, -1, -1, 2, 1, 32'h0, -1);
        idle_gap(1'b1);
        run_txn(32'h330, 0, 0, 0, -1, -1, 2, 1, 32'h0, -1);
        run_txn(32'h550, 0, 0, 0, -1, -1, 2, 1, 32'h0, 2);
        run_txn(32'h550, 0, 0, 0, -1, -1, 2, 1, 32'h0, -1);
        run_txn(32'h660, 0, 1, 0, -1, -1, 2, 1, 32'h0, -1);
        run_txn(32'h660, 1, 0, 0, -1, -1, 2, 1, 32'h0, -1);
        run_txn(32'h770, 0, 0, 0, 4, -1, 2, 1, 32'h0, -1);
        run_txn(32'h770, 0, 0, 0, -1, -1, 2, 1, 32'h0, -1);
        run_txn(32'h660, 0, 0, 1, -1, -1, 2, 1, 32'h0, -1);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            int fa, ia, ra, v;
            a  = {22'h0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 4'($urandom)};
            fa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 5) : -1;
            v  = $urandom_range(0, 4);
            ia = ($urandom_range(0, 7) == 0) ? ((v == 4) ? 5 : v) : -1;
            ra = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 3) : -1;
            run_txn(a, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                    $urandom_range(0, 14) == 0, fa, ia, $urandom_range(1, 4), 2, 32'h0, ra);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_gap($urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
